fft_input_reorder: RTL and testbench

FFT_INPUT_REORDER -- requirements
Module: fft_input_reorder

---
 rtl/fft_input_reorder.sv | 132 +++++++++++++
 tb/tb_fft_input_reorder.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_input_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_input_reorder
// Purpose  : Ping-pong bit-reversal reorder buffer in front of a radix-2 FFT.
// Revision : 1.0
// ============================================================================
module fft_input_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2N      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_real,
  input  logic signed [DATA_WIDTH-1:0]  in_imag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [2*DATA_WIDTH-1:0] out_real,
  output logic signed [2*DATA_WIDTH-1:0] out_imag,
  output logic                          out_sof,
  output logic                          out_eof
);

  localparam int               c_depth    = 1 << LOG2N;
  localparam logic [LOG2N-1:0] c_last_idx = '1;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  bank_state_t            bank_state_q [2];
  bank_state_t            bank_state_d [2];
  logic                   wr_bank_q, wr_bank_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]       wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]       rd_cnt_q, rd_cnt_d;
  logic [2*DATA_WIDTH-1:0] mem_q [2*c_depth];
  logic [2*DATA_WIDTH-1:0] w_rd_word;
  logic                   w_in_xfer;
  logic                   w_out_xfer;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = k[LOG2N-1-i];
    end
    return r;
  endfunction

  assign in_ready   = (bank_state_q[wr_bank_q] == BANK_EMPTY) ||
                      (bank_state_q[wr_bank_q] == BANK_FILLING);
  assign out_valid  = (bank_state_q[rd_bank_q] == BANK_FULL) ||
                      (bank_state_q[rd_bank_q] == BANK_DRAINING);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  // Write and read always target different banks, so both updates can land on one edge.
  always_comb begin
    bank_state_d[0] = bank_state_q[0];
    bank_state_d[1] = bank_state_q[1];
    wr_bank_d       = wr_bank_q;
    wr_cnt_d        = wr_cnt_q;
    rd_bank_d       = rd_bank_q;
    rd_cnt_d        = rd_cnt_q;
    if (w_in_xfer) begin
      if (wr_cnt_q == c_last_idx) begin
        bank_state_d[wr_bank_q] = BANK_FULL;
        wr_bank_d               = ~wr_bank_q;
        wr_cnt_d                = '0;
      end else begin
        bank_state_d[wr_bank_q] = BANK_FILLING;
        wr_cnt_d                = wr_cnt_q + LOG2N'(1);
      end
    end
    if (w_out_xfer) begin
      if (rd_cnt_q == c_last_idx) begin
        bank_state_d[rd_bank_q] = BANK_EMPTY;
        rd_bank_d               = ~rd_bank_q;
        rd_cnt_d                = '0;
      end else begin
        bank_state_d[rd_bank_q] = BANK_DRAINING;
        rd_cnt_d                = rd_cnt_q + LOG2N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_state_q[0] <= BANK_EMPTY;
      bank_state_q[1] <= BANK_EMPTY;
      wr_bank_q       <= 1'b0;
      wr_cnt_q        <= '0;
      rd_bank_q       <= 1'b0;
      rd_cnt_q        <= '0;
    end else begin
      bank_state_q[0] <= bank_state_d[0];
      bank_state_q[1] <= bank_state_d[1];
      wr_bank_q       <= wr_bank_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_bank_q       <= rd_bank_d;
      rd_cnt_q        <= rd_cnt_d;
    end
  end

  // Sample storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      mem_q[{wr_bank_q, bitrev(wr_cnt_q)}] <= {in_real, in_imag};
    end
  end

  assign w_rd_word = mem_q[{rd_bank_q, rd_cnt_q}];

  always_comb begin
    out_real = '0;
    out_imag = '0;
    out_sof  = 1'b0;
    out_eof  = 1'b0;
    if (out_valid) begin
      out_real = {{DATA_WIDTH{w_rd_word[2*DATA_WIDTH-1]}}, w_rd_word[2*DATA_WIDTH-1 -: DATA_WIDTH]};
      out_imag = {{DATA_WIDTH{w_rd_word[DATA_WIDTH-1]}},   w_rd_word[DATA_WIDTH-1:0]};
      out_sof  = (rd_cnt_q == '0);
      out_eof  = (rd_cnt_q == c_last_idx);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_input_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_input_reorder
// Purpose  : Randomised self-checking bench for the FFT input reorder buffer.
// Revision : 1.0
// ============================================================================
module tb_fft_input_reorder;

  localparam int DW = 16;
  localparam int LG = 3;
  localparam int N  = 1 << LG;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0]   in_real;
  logic signed [DW-1:0]   in_imag;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [2*DW-1:0] out_real;
  logic signed [2*DW-1:0] out_imag;
  logic                 out_sof;
  logic                 out_eof;

  int checks = 0;
  int errors = 0;

  logic [2*DW-1:0]  part_q [$];
  logic [4*DW+1:0]  exp_q  [$];
  logic [4*DW+1:0]  obs_q  [$];

  fft_input_reorder #(.DATA_WIDTH(DW), .LOG2N(LG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real (out_real),
    .out_imag (out_imag),
    .out_sof  (out_sof),
    .out_eof  (out_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rev_index(input int k);
    int r;
    int v;
    r = 0;
    v = k;
    for (int i = 0; i < LG; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic logic [2*DW-1:0] sext(input logic [DW-1:0] v);
    int s;
    s = int'(v);
    if (s >= 32768) s = s - 65536;
    return 32'(s);
  endfunction

  // Reference model: gather a frame of accepted samples, emit it in bit-reversed order.
  always @(negedge clk) begin
    int k;
    if (!rst_n) begin
      part_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        part_q.push_back({in_real, in_imag});
        if (part_q.size() == N) begin
          for (int o = 0; o < N; o++) begin
            k = rev_index(o);
            exp_q.push_back({(o == 0), (o == N - 1),
                             sext(part_q[k][2*DW-1:DW]), sext(part_q[k][DW-1:0])});
          end
          part_q.delete();
        end
      end
      if (out_valid && out_ready) begin
        obs_q.push_back({out_sof, out_eof, out_real, out_imag});
      end
    end
  end

  task automatic send_sample(input logic [DW-1:0] r, input logic [DW-1:0] im, output int waits);
    logic taken;
    taken    = 1'b0;
    waits    = 0;
    in_valid = 1'b1;
    in_real  = r;
    in_imag  = im;
    while (!taken) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
      if (!taken) waits++;
      if (!taken && waits > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got in_ready=0 for %0d cycles want acceptance", waits);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int cyc;
    cyc = 0;
    while (obs_q.size() < n && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL wait_obs got %0d outputs want %0d", obs_q.size(), n);
    end
  endtask

  task automatic clear_queues();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks += 6;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    if (out_sof !== 1'b0) begin errors++; $display("FAIL rst_out_sof got %b want 0", out_sof); end
    if (out_eof !== 1'b0) begin errors++; $display("FAIL rst_out_eof got %b want 0", out_eof); end
    if (out_real !== 32'd0) begin errors++; $display("FAIL rst_out_real got %h want 0", out_real); end
    if (out_imag !== 32'd0) begin errors++; $display("FAIL rst_out_imag got %h want 0", out_imag); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_queues();
  endtask

  task automatic test_bitrev_order();
    int order [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int w;
    logic seen;
    logic [2*DW-1:0] want_r, want_i;
    clear_queues();
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) send_sample(DW'(k), DW'(-k), w);
    seen = 1'b0;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL latency got out_valid=0 want 1 within 2 edges"); end
    wait_obs(N);
    for (int j = 0; j < N && j < obs_q.size(); j++) begin
      want_r = order[j];
      want_i = -order[j];
      checks++;
      if (obs_q[j] !== {(j == 0), (j == N - 1), want_r, want_i}) begin
        errors++;
        $display("FAIL bitrev[%0d] got %h want %h", j, obs_q[j], {(j == 0), (j == N - 1), want_r, want_i});
      end
    end
  endtask

  task automatic test_sign_ext();
    int w;
    clear_queues();
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) send_sample(16'h8000, 16'h7FFF, w);
    wait_obs(N);
    for (int j = 0; j < N && j < obs_q.size(); j++) begin
      checks += 2;
      if (obs_q[j][4*DW-1:2*DW] !== 32'hFFFF8000) begin
        errors++; $display("FAIL sext_real[%0d] got %h want FFFF8000", j, obs_q[j][4*DW-1:2*DW]);
      end
      if (obs_q[j][2*DW-1:0] !== 32'h00007FFF) begin
        errors++; $display("FAIL sext_imag[%0d] got %h want 00007FFF", j, obs_q[j][2*DW-1:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [4*DW+1:0] held;
    clear_queues();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = 1'b1;
      in_real  = DW'($urandom);
      in_imag  = DW'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks += 3;
    if (acc !== 2 * N) begin errors++; $display("FAIL bp_accepted got %0d want %0d", acc, 2 * N); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    if (!(out_valid === 1'b1 && out_sof === 1'b1)) begin
      errors++; $display("FAIL bp_head got valid=%b sof=%b want 1 1", out_valid, out_sof);
    end
    held = {out_sof, out_eof, out_real, out_imag};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_sof, out_eof, out_real, out_imag} !== held) begin
      errors++; $display("FAIL bp_hold got %h want %h", {out_sof, out_eof, out_real, out_imag}, held);
    end
    out_ready = 1'b1;
    wait_obs(2 * N);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      checks++;
      if (obs_q[j] !== exp_q[j]) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", j, obs_q[j], exp_q[j]); end
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_drained_ready got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int total_waits;
    int gaps;
    clear_queues();
    out_ready   = 1'b1;
    total_waits = 0;
    gaps        = 0;
    fork
      begin
        int w;
        for (int k = 0; k < 4 * N; k++) begin
          send_sample(DW'($urandom), DW'($urandom), w);
          total_waits += w;
        end
      end
      begin
        int n;
        logic started;
        n = 0;
        started = 1'b0;
        for (int c = 0; c < 400 && n < 4 * N; c++) begin
          @(negedge clk);
          if (out_valid) begin
            started = 1'b1;
            if (out_ready) n++;
          end else if (started) begin
            gaps++;
          end
        end
      end
    join
    checks += 2;
    if (total_waits !== 0) begin errors++; $display("FAIL b2b_in_ready got %0d stall cycles want 0", total_waits); end
    if (gaps !== 0) begin errors++; $display("FAIL b2b_gaps got %0d want 0", gaps); end
    wait_obs(4 * N);
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      checks++;
      if (obs_q[j] !== exp_q[j]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", j, obs_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_random_stall();
    int acc;
    int cyc;
    logic prev_stall;
    logic [4*DW+1:0] prev;
    clear_queues();
    acc = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev = '0;
    while (obs_q.size() < 3 * N && cyc < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (acc < 3 * N) && ($urandom_range(0, 3) != 0);
      in_real   = DW'($urandom);
      in_imag   = DW'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (prev_stall) begin
        checks++;
        if (!(out_valid === 1'b1 && {out_sof, out_eof, out_real, out_imag} === prev)) begin
          errors++;
          $display("FAIL stall_hold got v=%b %h want v=1 %h", out_valid, {out_sof, out_eof, out_real, out_imag}, prev);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev = {out_sof, out_eof, out_real, out_imag};
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 3 * N) begin
      errors++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), 3 * N);
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      checks++;
      if (obs_q[j] !== exp_q[j]) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", j, obs_q[j], exp_q[j]); end
    end
  endtask

  task automatic test_reset_midframe();
    int order [N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int w;
    logic [2*DW-1:0] want_r, want_i;
    clear_queues();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_sample(DW'(100 + k), DW'(200 + k), w);
    rst_n = 1'b0;
    #2;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_queues();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) send_sample(DW'(k), DW'(-k), w);
    wait_obs(N);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() != N) begin errors++; $display("FAIL mid_count got %0d want %0d", obs_q.size(), N); end
    for (int j = 0; j < N && j < obs_q.size(); j++) begin
      want_r = order[j];
      want_i = -order[j];
      checks++;
      if (obs_q[j] !== {(j == 0), (j == N - 1), want_r, want_i}) begin
        errors++;
        $display("FAIL mid_data[%0d] got %h want %h", j, obs_q[j], {(j == 0), (j == N - 1), want_r, want_i});
      end
    end
  endtask

  initial begin
    test_reset();
    test_bitrev_order();
    test_sign_ext();
    test_backpressure();
    test_back_to_back();
    test_random_stall();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
